i2c_codec_responder: RTL



---
 rtl/i2c_codec_responder.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_codec_responder.sv
// WM8731-style I2C control-port target: ACKs address/data writes and mirrors them into a register file.
// Build option: define I2C_RESP_AUTOINC_EN to stream several address/data pairs in one transaction.
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         NUM_REGS = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oen,
  output logic       o_busy,
  output logic       o_wr_valid,
  output logic [6:0] o_wr_addr,
  output logic [8:0] o_wr_data,
  output logic       o_err,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_ACK_A  = 3'd2,
    S_BYTE0  = 3'd3,
    S_ACK_0  = 3'd4,
    S_BYTE1  = 3'd5,
    S_ACK_1  = 3'd6,
    S_IGNORE = 3'd7
  } state_e;

  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

  logic       scl_meta_q, scl_q, scl_prev_q;
  logic       sda_meta_q, sda_q, sda_prev_q;
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [6:0] reg_addr_q, reg_addr_d;
  logic       data8_q, data8_d;
  logic       oen_q, oen_d;
  logic       busy_q, busy_d;
  logic       extra_q, extra_d;
  logic       wr_valid_q, wr_valid_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [8:0] wr_data_q, wr_data_d;
  logic       err_q, err_d;
  logic       commit;
  logic [8:0] regs_q [NUM_REGS];
  logic [8:0] rd_data_q;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic       is_shift, is_ack;
  logic [7:0] shifted;
  logic [3:0] cnt_inc;

  assign scl_rise  = scl_q & ~scl_prev_q;
  assign scl_fall  = ~scl_q & scl_prev_q;
  assign start_det = scl_q & scl_prev_q & sda_prev_q & ~sda_q;
  assign stop_det  = scl_q & scl_prev_q & ~sda_prev_q & sda_q;
  assign is_shift  = (state_q == S_ADDR) || (state_q == S_BYTE0) || (state_q == S_BYTE1);
  assign is_ack    = (state_q == S_ACK_A) || (state_q == S_ACK_0) || (state_q == S_ACK_1);
  assign shifted   = {shift_q[6:0], sda_q};
  assign cnt_inc   = cnt_q + 4'd1;

  // The SCL rise that precedes a START/STOP is itself counted as a bit, so a
  // single counted bit is not a partial byte; partial means two or more.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    reg_addr_d = reg_addr_q;
    data8_d    = data8_q;
    oen_d      = oen_q;
    busy_d     = busy_q;
    extra_d    = extra_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = 1'b0;
    commit     = 1'b0;
    if (stop_det) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      oen_d   = 1'b0;
      cnt_d   = 4'd0;
      extra_d = 1'b0;
      err_d   = is_shift && (cnt_q >= 4'd2);
    end else if (start_det) begin
      state_d = S_ADDR;
      busy_d  = 1'b1;
      oen_d   = 1'b0;
      cnt_d   = 4'd0;
      extra_d = 1'b0;
      err_d   = busy_q && ((is_shift && (cnt_q >= 4'd2)) || is_ack);
    end else begin
      case (state_q)
        S_ADDR, S_BYTE0, S_BYTE1: begin
          if (scl_rise) begin
            shift_d = shifted;
            cnt_d   = cnt_inc;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (state_q == S_ADDR) begin
                state_d = (shifted == {DEV_ADDR, 1'b0}) ? S_ACK_A : S_IGNORE;
              end else if (state_q == S_BYTE0) begin
                reg_addr_d = shifted[7:1];
                data8_d    = shifted[0];
                state_d    = S_ACK_0;
              end else begin
                commit     = 1'b1;
                wr_valid_d = 1'b1;
                wr_addr_d  = reg_addr_q;
                wr_data_d  = {data8_q, shifted};
                state_d    = S_ACK_1;
              end
            end
          end
        end
        S_ACK_A, S_ACK_0, S_ACK_1: begin
          // First SCL fall starts driving ACK, the second ends the ACK slot.
          if (scl_fall) begin
            if (!oen_q) begin
              oen_d = 1'b1;
            end else begin
              oen_d = 1'b0;
              if (state_q == S_ACK_A) begin
                state_d = S_BYTE0;
              end else if (state_q == S_ACK_0) begin
                state_d = S_BYTE1;
              end else begin
`ifdef I2C_RESP_AUTOINC_EN
                state_d = S_BYTE0;
`else
                state_d = S_IGNORE;
                extra_d = 1'b1;
`endif
              end
            end
          end
        end
        S_IGNORE: begin
          // Frames of 9 clocks; bytes after a completed write are errors.
          if (scl_rise) begin
            cnt_d = (cnt_q == 4'd8) ? 4'd0 : cnt_inc;
            err_d = extra_q && (cnt_q == 4'd7);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_meta_q <= 1'b1;
      scl_q      <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_q      <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'd0;
      reg_addr_q <= 7'd0;
      data8_q    <= 1'b0;
      oen_q      <= 1'b0;
      busy_q     <= 1'b0;
      extra_q    <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 7'd0;
      wr_data_q  <= 9'd0;
      err_q      <= 1'b0;
    end else begin
      scl_meta_q <= i_scl;
      scl_q      <= scl_meta_q;
      scl_prev_q <= scl_q;
      sda_meta_q <= i_sda;
      sda_q      <= sda_meta_q;
      sda_prev_q <= sda_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      reg_addr_q <= reg_addr_d;
      data8_q    <= data8_d;
      oen_q      <= oen_d;
      busy_q     <= busy_d;
      extra_q    <= extra_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
    end
  end

  // Register 0x0F is the codec reset register: writing it clears the file.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 9'd0;
      rd_data_q <= 9'd0;
    end else begin
      if (commit) begin
        if (reg_addr_q == 7'h0F) begin
          for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 9'd0;
        end else if ({1'b0, reg_addr_q} < NUM_REGS_W) begin
          regs_q[reg_addr_q[3:0]] <= wr_data_d;
        end
      end
      rd_data_q <= regs_q[i_rd_addr];
    end
  end

  assign o_sda_oen   = oen_q;
  assign o_busy      = busy_q;
  assign o_wr_valid  = wr_valid_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_err       = err_q;
  assign o_rd_data   = rd_data_q;
  assign o_dbg_state = state_q;

endmodule
